vga_text_line: RTL and testbench

VGA_TEXT_LINE -- requirements
Module: vga_text_line

---
 rtl/vga_text_line.sv | 181 ++++++++++++++++++
 tb/tb_vga_text_line.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_line.sv
// Single-line text overlay on a VGA pixel stream: character buffer, 8x8 font lookup,
// blinking cursor, two-stage pipeline from strVGA to strRGB.

// Minimal glyph table: NUL and space blank, 'A' drawn, every other code a solid block.
module fontROM (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_en,
    input  logic [11:0] addr,
    output logic [7:0]  dout
);
    logic [7:0] w_row;

    always_comb begin
        w_row = 8'hFF;
        if (addr[11] || addr[10:3] == 8'h00 || addr[10:3] == 8'h20) begin
            w_row = '0;
        end else if (addr[10:3] == 8'h41) begin
            case (addr[2:0])
                3'd0:                   w_row = 8'h0C;
                3'd1:                   w_row = 8'h1E;
                3'd2, 3'd3, 3'd5, 3'd6: w_row = 8'h33;
                3'd4:                   w_row = 8'h3F;
                default:                w_row = 8'h00;
            endcase
        end
    end

    // The table is fixed; write_en only stalls the read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (!write_en) begin
            dout <= w_row;
        end
    end
endmodule

module vga_text_line #(
    parameter  int NCHARS     = 16,
    parameter  int ZOOM_LOG2  = 3,
    parameter  int BLINK_LOG2 = 5,
    localparam int AW         = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
    input  logic          px_clk,
    input  logic          rst_n,
    input  logic [22:0]   strVGA,
    input  logic [9:0]    x_pos,
    input  logic [9:0]    y_pos,
    input  logic [2:0]    fg,
    input  logic [2:0]    bg,
    input  logic          bg_en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          cursor_en,
    input  logic [AW-1:0] cursor_pos,
    output logic [25:0]   strRGB
);
    localparam int CELL  = 8 << ZOOM_LOG2;
    localparam int BOX_W = NCHARS * CELL;
    localparam int CSH   = ZOOM_LOG2 + 3;

    logic [7:0]          r_buf [NCHARS];
    logic                r_vs_prev;
    logic [BLINK_LOG2:0] r_frame;

    logic [22:0] r_vga1;
    logic        r_in1;
    logic [2:0]  r_col1;
    logic        r_hit1;
    logic [2:0]  r_fg1;
    logic [2:0]  r_bg1;
    logic        r_bgen1;
    logic [25:0] r_out;

    logic [9:0]    w_xc, w_yc, w_dx, w_dy, w_cell;
    logic [16:0]   w_x_end, w_y_end;
    logic          w_inside, w_hit, w_wr_ok, w_pix;
    logic [2:0]    w_col, w_row;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_char, w_glyph;
    logic [2:0]    w_fgc, w_bgc, w_rgb;
    logic          w_bgen;

    assign w_xc = strVGA[22:13];
    assign w_yc = strVGA[12:3];

    // Box limits are widened so x_pos/y_pos near 1023 do not wrap back to 0.
    assign w_x_end  = {7'd0, x_pos} + 17'(BOX_W);
    assign w_y_end  = {7'd0, y_pos} + 17'(CELL);
    assign w_inside = (w_xc >= x_pos) && ({7'd0, w_xc} < w_x_end) &&
                      (w_yc >= y_pos) && ({7'd0, w_yc} < w_y_end);

    assign w_dx   = w_xc - x_pos;
    assign w_dy   = w_yc - y_pos;
    assign w_cell = w_dx >> CSH;
    assign w_col  = 3'(w_dx >> ZOOM_LOG2);
    assign w_row  = 3'(w_dy >> ZOOM_LOG2);
    assign w_idx  = AW'(w_cell);
    assign w_hit  = cursor_en && (w_cell == 10'(cursor_pos)) && r_frame[BLINK_LOG2];

    always_comb begin
        w_char = 8'h20;
        if (w_inside) begin
            w_char = r_buf[w_idx];
        end
    end

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < (AW+1)'(NCHARS));

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCHARS; i++) begin
                r_buf[i] <= 8'h20;
            end
        end else if (w_wr_ok) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= 1'b0;
            r_frame   <= '0;
        end else begin
            r_vs_prev <= strVGA[1];
            if (strVGA[1] && !r_vs_prev) begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    fontROM u_font (
        .clk      (px_clk),
        .rst_n    (rst_n),
        .write_en (1'b0),
        .addr     ({1'b0, w_char, w_row}),
        .dout     (w_glyph)
    );

    // Cursor swap forces the background on so an empty cell still shows the block.
    always_comb begin
        w_pix  = w_glyph[r_col1];
        w_fgc  = r_hit1 ? r_bg1 : r_fg1;
        w_bgc  = r_hit1 ? r_fg1 : r_bg1;
        w_bgen = r_hit1 | r_bgen1;
        w_rgb  = '0;
        if (r_vga1[0] && r_in1) begin
            if (w_pix) begin
                w_rgb = w_fgc;
            end else if (w_bgen) begin
                w_rgb = w_bgc;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga1  <= '0;
            r_in1   <= 1'b0;
            r_col1  <= '0;
            r_hit1  <= 1'b0;
            r_fg1   <= '0;
            r_bg1   <= '0;
            r_bgen1 <= 1'b0;
            r_out   <= '0;
        end else begin
            r_vga1  <= strVGA;
            r_in1   <= w_inside;
            r_col1  <= w_col;
            r_hit1  <= w_hit;
            r_fg1   <= fg;
            r_bg1   <= bg;
            r_bgen1 <= bg_en;
            r_out   <= {w_rgb, r_vga1};
        end
    end

    assign strRGB = r_out;
endmodule

// File: tb/tb_vga_text_line.sv
// Directed bench for vga_text_line: two instances (default geometry and a small
// NCHARS=10 / ZOOM_LOG2=0 / BLINK_LOG2=1 variant) fed the same pixel stream.
module tb_vga_text_line;
    logic px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    logic        rst_n;
    logic [22:0] strVGA;
    logic [9:0]  x_pos, y_pos;
    logic [2:0]  fg, bg;
    logic        bg_en;
    logic        wr_en1, wr_en2;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        cursor_en;
    logic [3:0]  cursor_pos;
    logic [25:0] rgb1, rgb2;

    vga_text_line #(.NCHARS(16), .ZOOM_LOG2(3), .BLINK_LOG2(5)) dut1 (
        .px_clk(px_clk), .rst_n(rst_n), .strVGA(strVGA), .x_pos(x_pos), .y_pos(y_pos),
        .fg(fg), .bg(bg), .bg_en(bg_en), .wr_en(wr_en1), .wr_addr(wr_addr),
        .wr_data(wr_data), .cursor_en(cursor_en), .cursor_pos(cursor_pos), .strRGB(rgb1)
    );

    vga_text_line #(.NCHARS(10), .ZOOM_LOG2(0), .BLINK_LOG2(1)) dut2 (
        .px_clk(px_clk), .rst_n(rst_n), .strVGA(strVGA), .x_pos(x_pos), .y_pos(y_pos),
        .fg(fg), .bg(bg), .bg_en(bg_en), .wr_en(wr_en2), .wr_addr(wr_addr),
        .wr_data(wr_data), .cursor_en(cursor_en), .cursor_pos(cursor_pos), .strRGB(rgb2)
    );

    typedef struct {
        logic [9:0] xc, yc;
        logic       act;
        logic [9:0] xp, yp;
        logic [2:0] f, b;
        logic       be;
        logic [2:0] e1, e2;
    } vec_t;

    vec_t       tbl[$];
    int         total = 0;
    int         bad   = 0;
    logic       pc1 = 1'b0, pc2 = 1'b0;
    logic [2:0] pe1, pe2;
    logic [22:0] pvga;
    string      pname;
    logic [7:0] font_a [8] = '{8'h0C, 8'h1E, 8'h33, 8'h33, 8'h3F, 8'h33, 8'h33, 8'h00};

    function automatic vec_t mk(input int xc, yc, act, xp, yp, f, b, be, e1, e2);
        vec_t v;
        v.xc = 10'(xc); v.yc = 10'(yc); v.act = 1'(act); v.xp = 10'(xp); v.yp = 10'(yp);
        v.f = 3'(f); v.b = 3'(b); v.be = 1'(be); v.e1 = 3'(e1); v.e2 = 3'(e2);
        return v;
    endfunction

    task automatic check(input string nm, input logic [25:0] got, input logic [25:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic set_px(input logic [9:0] xc, input logic [9:0] yc, input logic act, input logic vs);
        strVGA = {xc, yc, xc[0], vs, act};
    endtask

    task automatic set_cfg(input logic [9:0] xp, input logic [9:0] yp, input logic [2:0] f,
                           input logic [2:0] b, input logic be);
        x_pos = xp; y_pos = yp; fg = f; bg = b; bg_en = be;
    endtask

    // One clock: outputs now hold the pixel driven one call earlier.
    task automatic cyc(input string nm, input logic c1, input logic [2:0] e1,
                       input logic c2, input logic [2:0] e2);
        @(posedge px_clk);
        #1;
        if (pc1) check({pname, "/dut1"}, rgb1, {pe1, pvga});
        if (pc2) check({pname, "/dut2"}, rgb2, {pe2, pvga});
        pc1 = c1; pe1 = e1; pc2 = c2; pe2 = e2; pvga = strVGA; pname = nm;
    endtask

    task automatic wr(input logic which, input logic [3:0] a, input logic [7:0] d);
        wr_addr = a; wr_data = d;
        if (which) wr_en2 = 1'b1;
        else       wr_en1 = 1'b1;
        cyc("wr", 1'b0, 3'd0, 1'b0, 3'd0);
        wr_en1 = 1'b0; wr_en2 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0; wr_addr = '0; wr_data = '0;
        cursor_en = 1'b0; cursor_pos = '0;
        set_cfg(10'd0, 10'd0, 3'd7, 3'd1, 1'b1);
        set_px(10'd3, 10'd2, 1'b1, 1'b0);

        repeat (3) begin @(posedge px_clk); #1; end
        check("reset/dut1", rgb1, 26'd0);
        check("reset/dut2", rgb2, 26'd0);
        rst_n = 1'b1;

        wr(1'b0, 4'd3, 8'h5A);
        wr(1'b0, 4'd4, 8'h41);
        wr(1'b1, 4'd0, 8'h41);

        tbl.push_back(mk(   0,   0, 1,    0,  0, 7, 1, 1, 1, 1));
        tbl.push_back(mk(1023,   0, 1,    0,  0, 7, 1, 1, 1, 0));
        tbl.push_back(mk(   5,  63, 1,    0,  0, 7, 1, 1, 1, 0));
        tbl.push_back(mk(   5,  64, 1,    0,  0, 7, 1, 1, 0, 0));
        tbl.push_back(mk(   2,   0, 1,    0,  0, 7, 1, 0, 0, 7));
        tbl.push_back(mk(   2,   0, 0,    0,  0, 7, 1, 1, 0, 0));
        tbl.push_back(mk( 202,   5, 1,    0,  0, 6, 1, 1, 6, 0));
        tbl.push_back(mk( 202,   5, 0,    0,  0, 6, 1, 1, 0, 0));
        tbl.push_back(mk( 256,  16, 1,    0,  0, 6, 1, 1, 6, 0));
        tbl.push_back(mk( 272,  16, 1,    0,  0, 6, 1, 1, 1, 0));
        tbl.push_back(mk( 288,  32, 1,    0,  0, 6, 1, 1, 6, 0));
        tbl.push_back(mk( 256,  56, 1,    0,  0, 6, 1, 1, 1, 0));
        tbl.push_back(mk(1023,   0, 1, 1000,  0, 7, 1, 1, 1, 1));
        tbl.push_back(mk( 999,   0, 1, 1000,  0, 7, 1, 1, 0, 0));
        tbl.push_back(mk(   5,   0, 1, 1000,  0, 7, 1, 1, 0, 0));
        tbl.push_back(mk(1000,   0, 1, 1000,  0, 7, 1, 1, 1, 1));
        tbl.push_back(mk(1002,   0, 1, 1000,  0, 7, 1, 1, 1, 7));
        tbl.push_back(mk( 100,  50, 1,  100, 50, 7, 1, 1, 1, 1));
        tbl.push_back(mk(  99,  50, 1,  100, 50, 7, 1, 1, 0, 0));
        tbl.push_back(mk( 100, 113, 1,  100, 50, 7, 1, 1, 1, 0));
        tbl.push_back(mk( 100, 114, 1,  100, 50, 7, 1, 1, 0, 0));
        tbl.push_back(mk( 100,  57, 1,  100, 50, 7, 1, 1, 1, 1));
        tbl.push_back(mk( 179,  50, 1,  100, 50, 7, 1, 1, 1, 1));
        tbl.push_back(mk( 180,  50, 1,  100, 50, 7, 1, 1, 1, 0));
        tbl.push_back(mk( 100,  49, 1,  100, 50, 7, 1, 1, 0, 0));
        tbl.push_back(mk(   0,   0, 1,    0,  0, 2, 5, 1, 5, 5));
        tbl.push_back(mk(   3,   1, 1,    0,  0, 2, 5, 1, 5, 2));

        foreach (tbl[i]) begin
            set_cfg(tbl[i].xp, tbl[i].yp, tbl[i].f, tbl[i].b, tbl[i].be);
            set_px(tbl[i].xc, tbl[i].yc, tbl[i].act, 1'b0);
            cyc($sformatf("tbl%0d", i), 1'b1, tbl[i].e1, 1'b1, tbl[i].e2);
        end

        // Glyph 'A' in cell 0 of the unzoomed instance, cell 1 stays blank.
        set_cfg(10'd0, 10'd0, 3'd7, 3'd1, 1'b1);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                set_px(10'(c), 10'(r), 1'b1, 1'b0);
                cyc($sformatf("glyph_r%0d_c%0d", r, c), 1'b1, 3'd1, 1'b1,
                    (c < 8 && font_a[r][c]) ? 3'd7 : 3'd1);
            end
        end

        // Write and render of the same cell on the same edge sees the old contents.
        set_px(10'd16, 10'd0, 1'b1, 1'b0);
        wr_addr = 4'd2; wr_data = 8'h5A; wr_en2 = 1'b1;
        cyc("wr_same_edge", 1'b1, 3'd1, 1'b1, 3'd1);
        wr_en2 = 1'b0;
        cyc("wr_next_edge", 1'b1, 3'd1, 1'b1, 3'd7);

        for (int a = 10; a < 16; a++) wr(1'b1, 4'(a), 8'h5A);
        for (int c = 0; c < 10; c++) begin
            set_px(10'(c * 8 + 2), 10'd0, 1'b1, 1'b0);
            cyc($sformatf("oob_cell%0d", c), 1'b1, 3'd1, 1'b1,
                (c == 0 || c == 2) ? 3'd7 : 3'd1);
        end

        // Cursor on cell 2 with bg_en off: blank cell shows fg only while blink phase is 1.
        wr(1'b1, 4'd2, 8'h20);
        set_cfg(10'd0, 10'd0, 3'd7, 3'd1, 1'b0);
        cursor_en = 1'b1; cursor_pos = 4'd2;
        for (int f = 0; f < 6; f++) begin
            set_px(10'd16, 10'd0, 1'b1, 1'b0);
            cyc($sformatf("cursor_f%0d", f), 1'b1, 3'd0, 1'b1, (f == 2 || f == 3) ? 3'd7 : 3'd0);
            set_px(10'd8, 10'd0, 1'b1, 1'b0);
            cyc($sformatf("nocursor_f%0d", f), 1'b1, 3'd0, 1'b1, 3'd0);
            set_px(10'd500, 10'd500, 1'b0, 1'b1);
            cyc("vs_hi", 1'b0, 3'd0, 1'b0, 3'd0);
            set_px(10'd500, 10'd500, 1'b0, 1'b0);
            cyc("vs_lo", 1'b0, 3'd0, 1'b0, 3'd0);
        end

        // Mid-frame reset: output clears without a clock edge, then refills with zeros.
        set_cfg(10'd0, 10'd0, 3'd7, 3'd1, 1'b1);
        set_px(10'd2, 10'd0, 1'b1, 1'b0);
        cyc("pre_rst", 1'b1, 3'd1, 1'b1, 3'd7);
        cyc("pre_rst2", 1'b1, 3'd1, 1'b1, 3'd7);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst/dut1", rgb1, 26'd0);
        check("async_rst/dut2", rgb2, 26'd0);
        pc1 = 1'b0; pc2 = 1'b0;
        repeat (2) begin @(posedge px_clk); #1; end
        rst_n = 1'b1;
        @(posedge px_clk);
        #1;
        check("refill/dut1", rgb1, 26'd0);
        check("refill/dut2", rgb2, 26'd0);
        pc1 = 1'b1; pe1 = 3'd1; pc2 = 1'b1; pe2 = 3'd1; pvga = strVGA; pname = "post_rst_buf";
        set_cfg(10'd0, 10'd0, 3'd7, 3'd1, 1'b0);
        set_px(10'd16, 10'd0, 1'b1, 1'b0);
        cyc("post_rst_frame", 1'b1, 3'd0, 1'b1, 3'd0);
        cyc("flush", 1'b0, 3'd0, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
